fifo_rr_scheduler: RTL and testbench
====================================

// Module: fifo_rr_scheduler
// PURPOSE
//  Shares one synchronous FIFO (1-cycle registered read, full/empty flags) between NUM_REQ producers.
//  Round-robin write arbitration with optional burst lock; each word is tagged with its source ID.
//  Drains the FIFO to one consumer over valid/ready, hiding the FIFO read latency at full throughput.
//  Sits between producer ports and the FIFO instance; drives wren/rden/data_in, observes flags/data_out.
// PARAMETERS
//  NUM_REQ     4                   number of producer ports (>=2)
//  DATA_WIDTH  7                   payload bits per producer word
//  BURST_LEN   1                   max consecutive beats granted to one producer before rotating (>=1)
//  ID_WIDTH    $clog2(NUM_REQ)     source-tag width (derived, not overridden)
//  FIFO_WIDTH  ID_WIDTH+DATA_WIDTH FIFO word = {src_id, payload} (derived)
// PORTS
//  clock       in   1                     rising-edge clock
//  reset_n     in   1                     asynchronous, active-low reset
//  s_valid     in   NUM_REQ               producer i has a word
//  s_data      in   NUM_REQ*DATA_WIDTH    producer i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_ready     out  NUM_REQ               one-hot/zero; word i accepted when s_valid[i]&&s_ready[i]
//  fifo_wren   out  1                     FIFO write enable
//  fifo_wdata  out  FIFO_WIDTH            FIFO write word {id, payload}
//  fifo_rden   out  1                     FIFO read enable
//  fifo_full   in   1                     FIFO full flag
//  fifo_empty  in   1                     FIFO empty flag
//  fifo_rdata  in   FIFO_WIDTH            FIFO registered read data (valid cycle after rden, held)
//  m_valid     out  1                     consumer word valid
//  m_ready     in   1                     consumer accepts
//  m_data      out  DATA_WIDTH            = fifo_rdata[DATA_WIDTH-1:0]
//  m_src       out  ID_WIDTH              = fifo_rdata[FIFO_WIDTH-1 -: ID_WIDTH]
// BEHAVIOUR
//  Reset: m_valid=0, s_ready=0, fifo_wren=0, fifo_rden=0, rr_ptr=0, beat_cnt=0, write FSM=ARB.
//  Write side (combinational outputs from registered state):
//   - fifo_full=1 -> s_ready=0, fifo_wren=0, even if a read happens same cycle (FIFO drops writes when full).
//   - ARB: grant = first i with s_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - Grant g with !fifo_full -> s_ready[g]=1, fifo_wren=1, fifo_wdata={g, s_data[g]}.
//   - Accepted beat: if BURST_LEN>1 -> LOCKED on g, beat_cnt=1; else rr_ptr<=g+1 (wrap NUM_REQ-1->0).
//   - LOCKED: grant held on g regardless of others; each accepted beat beat_cnt++;
//     beat_cnt reaches BURST_LEN or s_valid[g] drops -> rr_ptr<=g+1, beat_cnt<=0, ARB.
//   - Stall on fifo_full in LOCKED keeps lock; beat_cnt unchanged.
//  Read side, 1-bit state m_valid:
//   - fifo_rden = !fifo_empty && (!m_valid || m_ready).
//   - fifo_rden -> m_valid<=1 next cycle (data appears on fifo_rdata then).
//   - m_valid && m_ready && fifo_empty -> m_valid<=0.  Full throughput: 1 word/cycle when FIFO non-empty.
//   - m_valid && !m_ready -> m_data/m_src stable (no rden issued).
//  Simultaneous fifo_wren and fifo_rden allowed whenever !fifo_full && !fifo_empty.
//  Empty FIFO + write this cycle: no read this cycle (empty still 1); first read next cycle; latency write->m_valid = 2 cycles.
//  Ordering: per producer, words reach consumer in acceptance order; no word lost or duplicated.
//  reset_n mid-operation: all state cleared asynchronously; FIFO reset on same reset_n, in-flight words discarded.
// STRUCTURE
//  Package fifo_sched_pkg: wr_state_t enum {ARB, LOCKED}; function rr_pick(valid, ptr) -> id.
//  Sub-module rr_arbiter (NUM_REQ): valid vector + rr_ptr in -> grant_id, grant_vld out (combinational).
//  Top holds write FSM, rr_ptr, beat_cnt, m_valid, and FIFO word packing/unpacking.
// TESTING
//  All s_valid=1, BURST_LEN=1, m_ready=1 -> fifo_wdata ids 0,1,2,3,0,... one per cycle; m_src same order 2 cycles later.
//  BURST_LEN=3, s_valid=4'b0011 -> ids 0,0,0,1,1,1,0,...; drop s_valid[0] after 1 beat -> rotates to 1 next cycle.
//  Fill 4-deep FIFO with m_ready=0 -> fifo_full=1, s_ready=0, fifo_wren=0; raise m_ready -> first drain, write resumes next cycle.
//  m_ready toggling 1010 with FIFO non-empty -> m_data held while !m_ready, no rden; every word seen exactly once.
//  Single producer 2, payload 7'h55 into empty FIFO -> m_valid at cycle+2, m_data=7'h55, m_src=2; then m_valid=0.
//  Assert reset_n mid-burst -> m_valid, s_ready, fifo_wren, fifo_rden =0 immediately; first grant after release is id 0.

Source files
------------

// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the FIFO round-robin scheduler.
// Holds the write-side state encoding and the rotating-priority search
// used by the arbiter.
package fifo_sched_pkg;

  // Write-side FSM: free arbitration, or holding a grant for a burst.
  typedef enum logic {
    ARB,
    LOCKED
  } wr_state_t;

  // Widest requester vector the search helper handles.
  localparam int MAX_REQ = 32;

  // Returns the first requester with valid set, scanning ptr, ptr+1, ...
  // and wrapping at numReq; returns -1 when nobody is requesting.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                 input int numReq,
                                 input int ptr);
    int pick;
    int idx;
    pick = -1;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < numReq) begin
        idx = ptr + k;
        if (idx >= numReq) begin
          idx = idx - numReq;
        end
        if (pick < 0 && valid[idx[4:0]]) begin
          pick = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the rotating pointer. Purely combinational; the pointer lives in the top.
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid_i,
  input  logic [ID_WIDTH-1:0] rr_ptr_i,
  output logic [ID_WIDTH-1:0] grant_id_o,
  output logic                grant_vld_o
);

  logic [MAX_REQ-1:0] validWide;
  int                 pick;

  // Widen the request vector and run the rotating-priority search.
  always_comb begin
    validWide                = '0;
    validWide[NUM_REQ-1:0]   = valid_i;
    pick                     = rr_pick(validWide, NUM_REQ, int'(rr_ptr_i));
    grant_vld_o              = (pick >= 0);
    grant_id_o               = ID_WIDTH'(pick);
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Shares one synchronous FIFO between NUM_REQ producers. Writes are granted
// round-robin (optionally locked for up to BURST_LEN beats) and tagged with
// the source id; the read side hides the FIFO's one-cycle read latency so
// the consumer can take one word per cycle.
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 7,
  parameter int BURST_LEN  = 1,
  localparam int ID_WIDTH   = $clog2(NUM_REQ),
  localparam int FIFO_WIDTH = ID_WIDTH + DATA_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            s_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data_i,
  output logic [NUM_REQ-1:0]            s_ready_o,
  output logic                          fifo_wren_o,
  output logic [FIFO_WIDTH-1:0]         fifo_wdata_o,
  output logic                          fifo_rden_o,
  input  logic                          fifo_full_i,
  input  logic                          fifo_empty_i,
  input  logic [FIFO_WIDTH-1:0]         fifo_rdata_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  output logic [ID_WIDTH-1:0]           m_src_o
);

  localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);

  wr_state_t             state_q, state_d;
  logic [ID_WIDTH-1:0]   rrPtr_q, rrPtr_d;
  logic [ID_WIDTH-1:0]   lockId_q, lockId_d;
  logic [CNT_WIDTH-1:0]  beatCnt_q, beatCnt_d;
  logic                  mValid_q, mValid_d;

  logic [ID_WIDTH-1:0]   arbId;
  logic                  arbVld;
  logic [ID_WIDTH-1:0]   grantId;
  logic [ID_WIDTH-1:0]   nextPtr;
  logic                  accept;
  logic                  readNow;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arbiter (
    .valid_i     (s_valid_i),
    .rr_ptr_i    (rrPtr_q),
    .grant_id_o  (arbId),
    .grant_vld_o (arbVld)
  );

  // Write-side next state: pick the grant, decide acceptance, and advance
  // the pointer / burst counter. A full FIFO blocks every write.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    lockId_d  = lockId_q;
    beatCnt_d = beatCnt_q;
    accept    = 1'b0;
    grantId   = (state_q == LOCKED) ? lockId_q : arbId;
    nextPtr   = (grantId == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grantId + ID_WIDTH'(1);
    case (state_q)
      ARB: begin
        if (arbVld && !fifo_full_i) begin
          accept = 1'b1;
          if (BURST_LEN > 1) begin
            state_d   = LOCKED;
            lockId_d  = arbId;
            beatCnt_d = CNT_WIDTH'(1);
          end else begin
            rrPtr_d = nextPtr;
          end
        end
      end
      LOCKED: begin
        if (!s_valid_i[lockId_q]) begin
          rrPtr_d   = nextPtr;
          beatCnt_d = '0;
          state_d   = ARB;
        end else if (!fifo_full_i) begin
          accept = 1'b1;
          if (beatCnt_q == CNT_WIDTH'(BURST_LEN - 1)) begin
            rrPtr_d   = nextPtr;
            beatCnt_d = '0;
            state_d   = ARB;
          end else begin
            beatCnt_d = beatCnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // Producer handshake and FIFO write port; forced quiet while in reset.
  always_comb begin
    s_ready_o    = '0;
    fifo_wren_o  = 1'b0;
    fifo_wdata_o = {grantId, s_data_i[grantId*DATA_WIDTH +: DATA_WIDTH]};
    if (accept && reset_n) begin
      s_ready_o   = NUM_REQ'(1) << grantId;
      fifo_wren_o = 1'b1;
    end
  end

  // Read side: fetch whenever the output slot is free or being emptied,
  // so back-to-back words stream at one per cycle.
  always_comb begin
    readNow     = !fifo_empty_i && (!mValid_q || m_ready_i);
    fifo_rden_o = readNow && reset_n;
    mValid_d    = mValid_q;
    if (readNow) begin
      mValid_d = 1'b1;
    end else if (mValid_q && m_ready_i) begin
      mValid_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously together with the FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB;
      rrPtr_q   <= '0;
      lockId_q  <= '0;
      beatCnt_q <= '0;
      mValid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      lockId_q  <= lockId_d;
      beatCnt_q <= beatCnt_d;
      mValid_q  <= mValid_d;
    end
  end

  assign m_valid_o = mValid_q;
  assign m_data_o  = fifo_rdata_i[DATA_WIDTH-1:0];
  assign m_src_o   = fifo_rdata_i[FIFO_WIDTH-1 -: ID_WIDTH];

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: two instances (BURST_LEN 1 and 3), each with
// its own 4-deep behavioural FIFO, exercised by directed scenarios and a
// randomized run against a queue-based reference model.
module tb_fifo_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int DW    = 7;
  localparam int IDW   = 2;
  localparam int FW    = IDW + DW;
  localparam int DEPTH = 4;
  localparam logic [NREQ*DW-1:0] DIR_DATA = {7'h44, 7'h33, 7'h22, 7'h11};

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic [NREQ-1:0]    sValid [2];
  logic [NREQ*DW-1:0] sData  [2];
  logic [NREQ-1:0]    sReady [2];
  logic               fWren  [2];
  logic [FW-1:0]      fWdata [2];
  logic               fRden  [2];
  logic               fFull  [2];
  logic               fEmpty [2];
  logic [FW-1:0]      fRdata [2];
  logic               mValid [2];
  logic               mReady [2];
  logic [DW-1:0]      mData  [2];
  logic [IDW-1:0]     mSrc   [2];

  int checks = 0;
  int errors = 0;

  // Free-running 10-time-unit clock.
  always #5 clock = ~clock;

  fifo_rr_scheduler #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .BURST_LEN(1)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .s_valid_i(sValid[0]), .s_data_i(sData[0]), .s_ready_o(sReady[0]),
    .fifo_wren_o(fWren[0]), .fifo_wdata_o(fWdata[0]), .fifo_rden_o(fRden[0]),
    .fifo_full_i(fFull[0]), .fifo_empty_i(fEmpty[0]), .fifo_rdata_i(fRdata[0]),
    .m_valid_o(mValid[0]), .m_ready_i(mReady[0]), .m_data_o(mData[0]), .m_src_o(mSrc[0])
  );

  fifo_rr_scheduler #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .BURST_LEN(3)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .s_valid_i(sValid[1]), .s_data_i(sData[1]), .s_ready_o(sReady[1]),
    .fifo_wren_o(fWren[1]), .fifo_wdata_o(fWdata[1]), .fifo_rden_o(fRden[1]),
    .fifo_full_i(fFull[1]), .fifo_empty_i(fEmpty[1]), .fifo_rdata_i(fRdata[1]),
    .m_valid_o(mValid[1]), .m_ready_i(mReady[1]), .m_data_o(mData[1]), .m_src_o(mSrc[1])
  );

  // Behavioural 4-deep FIFOs with registered, held read data; writes are
  // dropped when full even if a read happens in the same cycle.
  logic [FW-1:0] fMem [2][DEPTH];
  int fCnt [2];
  int fWp  [2];
  int fRp  [2];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < 2; n++) begin
        fCnt[n]   <= 0;
        fWp[n]    <= 0;
        fRp[n]    <= 0;
        fRdata[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (fRden[n] && fCnt[n] > 0) begin
          fRdata[n] <= fMem[n][fRp[n]];
          fRp[n]    <= (fRp[n] + 1) % DEPTH;
        end
        if (fWren[n] && fCnt[n] < DEPTH) begin
          fMem[n][fWp[n]] <= fWdata[n];
          fWp[n]          <= (fWp[n] + 1) % DEPTH;
        end
        fCnt[n] <= fCnt[n] + ((fWren[n] && fCnt[n] < DEPTH) ? 1 : 0)
                           - ((fRden[n] && fCnt[n] > 0) ? 1 : 0);
      end
    end
  end

  // FIFO flags follow the occupancy count.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      fFull[n]  = (fCnt[n] == DEPTH);
      fEmpty[n] = (fCnt[n] == 0);
    end
  end

  // Payload producer i carries in the directed tests.
  function automatic logic [DW-1:0] payloadOf(input int i);
    return DW'((i + 1) * 17);
  endfunction

  function automatic int burstOf(input int n);
    return (n == 0) ? 1 : 3;
  endfunction

  // Holds both instances in reset with all inputs idle, then releases
  // just after a rising edge so the next falling edge samples cycle 0.
  task automatic applyReset();
    reset_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      sValid[n] = '0;
      sData[n]  = '0;
      mReady[n] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Outputs are quiet in reset even with requests pending; first grant is id 0.
  task automatic test_reset();
    reset_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      sValid[n] = '1;
      sData[n]  = DIR_DATA;
      mReady[n] = 1'b1;
    end
    repeat (2) @(posedge clock);
    #3;
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (sReady[n] !== '0 || fWren[n] !== 1'b0 || fRden[n] !== 1'b0 || mValid[n] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_outputs inst%0d: got ready=%b wren=%b rden=%b mvalid=%b, want all 0",
                 n, sReady[n], fWren[n], fRden[n], mValid[n]);
      end
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (sReady[n] !== 4'b0001 || fWdata[n] !== {2'd0, payloadOf(0)}) begin
        errors++;
        $display("[TB] FAIL reset_first_grant inst%0d: got ready=%b wdata=%h, want 0001/%h",
                 n, sReady[n], fWdata[n], {2'd0, payloadOf(0)});
      end
    end
  endtask

  // All producers busy, BURST_LEN 1: ids rotate 0,1,2,3 and reach the
  // consumer two cycles later at one word per cycle.
  task automatic test_round_robin();
    logic [IDW-1:0] expId;
    logic [IDW-1:0] expSrc;
    applyReset();
    sValid[0] = '1;
    sData[0]  = DIR_DATA;
    mReady[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      expId = IDW'(c % NREQ);
      checks++;
      if (fWren[0] !== 1'b1 || sReady[0] !== (4'b0001 << expId) || fWdata[0] !== {expId, payloadOf(c % NREQ)}) begin
        errors++;
        $display("[TB] FAIL rr_write c%0d: got wren=%b ready=%b wdata=%h, want 1/%b/%h",
                 c, fWren[0], sReady[0], fWdata[0], 4'b0001 << expId, {expId, payloadOf(c % NREQ)});
      end
      if (c >= 2) begin
        expSrc = IDW'((c - 2) % NREQ);
        checks++;
        if (mValid[0] !== 1'b1 || mSrc[0] !== expSrc || mData[0] !== payloadOf((c - 2) % NREQ)) begin
          errors++;
          $display("[TB] FAIL rr_read c%0d: got valid=%b src=%0d data=%h, want 1/%0d/%h",
                   c, mValid[0], mSrc[0], mData[0], expSrc, payloadOf((c - 2) % NREQ));
        end
      end
      @(posedge clock);
      #1;
    end
  endtask

  // BURST_LEN 3 with producers 0 and 1: three beats each, then an early
  // drop of producer 0 hands the grant to producer 1.
  task automatic test_burst();
    int expIds [7] = '{0, 0, 0, 1, 1, 1, 0};
    logic [IDW-1:0] expId;
    applyReset();
    sValid[1] = 4'b0011;
    sData[1]  = DIR_DATA;
    mReady[1] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      expId = IDW'(expIds[c]);
      checks++;
      if (fWren[1] !== 1'b1 || sReady[1] !== (4'b0001 << expId) || fWdata[1][FW-1 -: IDW] !== expId) begin
        errors++;
        $display("[TB] FAIL burst_seq c%0d: got wren=%b ready=%b id=%0d, want 1/%b/%0d",
                 c, fWren[1], sReady[1], fWdata[1][FW-1 -: IDW], 4'b0001 << expId, expId);
      end
      @(posedge clock);
      #1;
    end
    sValid[1] = 4'b0010;
    @(negedge clock);
    checks++;
    if (fWren[1] !== 1'b0 || sReady[1] !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL burst_drop: got wren=%b ready=%b, want 0/0000", fWren[1], sReady[1]);
    end
    @(posedge clock);
    #1 sValid[1] = 4'b0011;
    @(negedge clock);
    checks++;
    if (sReady[1] !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL burst_rotate: got ready=%b, want 0010", sReady[1]);
    end
    @(posedge clock);
    #1;
  endtask

  // Fill the FIFO with the consumer stalled, then release it: the drain
  // cycle still blocks writes, the following cycle writes again.
  task automatic test_full();
    int waitCyc = 0;
    applyReset();
    sValid[0] = '1;
    sData[0]  = DIR_DATA;
    mReady[0] = 1'b0;
    @(negedge clock);
    while (!fFull[0] && waitCyc < 12) begin
      @(posedge clock);
      #1;
      @(negedge clock);
      waitCyc++;
    end
    checks++;
    if (fFull[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_reached: got full=%b after %0d cycles, want 1", fFull[0], waitCyc);
    end else begin
      checks++;
      if (sReady[0] !== '0 || fWren[0] !== 1'b0 || mValid[0] !== 1'b1 || fRden[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL full_block: got ready=%b wren=%b mvalid=%b rden=%b, want 0000/0/1/0",
                 sReady[0], fWren[0], mValid[0], fRden[0]);
      end
      @(posedge clock);
      #1 mReady[0] = 1'b1;
      @(negedge clock);
      checks++;
      if (fRden[0] !== 1'b1 || fWren[0] !== 1'b0 || sReady[0] !== '0 || mSrc[0] !== 2'd0) begin
        errors++;
        $display("[TB] FAIL full_drain: got rden=%b wren=%b ready=%b src=%0d, want 1/0/0000/0",
                 fRden[0], fWren[0], sReady[0], mSrc[0]);
      end
      @(posedge clock);
      #1;
      @(negedge clock);
      checks++;
      if (fWren[0] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL full_resume: got wren=%b, want 1", fWren[0]);
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Consumer ready toggling 1010 over four queued words: output held with
  // no read while stalled, every word delivered exactly once in order.
  task automatic test_toggle();
    int idx = 0;
    applyReset();
    sValid[0] = '1;
    sData[0]  = DIR_DATA;
    mReady[0] = 1'b0;
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    sValid[0] = '0;
    for (int c = 0; c < 12; c++) begin
      mReady[0] = (c % 2 == 0);
      @(negedge clock);
      if (mValid[0]) begin
        checks++;
        if (mReady[0]) begin
          if (idx >= NREQ || mSrc[0] !== IDW'(idx) || mData[0] !== payloadOf(idx)) begin
            errors++;
            $display("[TB] FAIL toggle_word c%0d: got src=%0d data=%h, want %0d/%h",
                     c, mSrc[0], mData[0], idx, payloadOf(idx));
          end
          idx++;
        end else if (fRden[0] !== 1'b0 || mSrc[0] !== IDW'(idx)) begin
          errors++;
          $display("[TB] FAIL toggle_hold c%0d: got rden=%b src=%0d, want 0/%0d", c, fRden[0], mSrc[0], idx);
        end
      end
      @(posedge clock);
      #1;
    end
    checks++;
    if (idx !== NREQ) begin
      errors++;
      $display("[TB] FAIL toggle_count: got %0d words, want %0d", idx, NREQ);
    end
  endtask

  // One word from producer 2 into an empty FIFO: visible two cycles later.
  task automatic test_single();
    applyReset();
    sValid[0]          = 4'b0100;
    sData[0]           = '0;
    sData[0][2*DW +: DW] = 7'h55;
    mReady[0]          = 1'b1;
    @(negedge clock);
    checks++;
    if (fWren[0] !== 1'b1 || sReady[0] !== 4'b0100 || fWdata[0] !== {2'd2, 7'h55}) begin
      errors++;
      $display("[TB] FAIL single_write: got wren=%b ready=%b wdata=%h, want 1/0100/%h",
               fWren[0], sReady[0], fWdata[0], {2'd2, 7'h55});
    end
    @(posedge clock);
    #1 sValid[0] = '0;
    @(negedge clock);
    checks++;
    if (mValid[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_early: got mvalid=%b at +1, want 0", mValid[0]);
    end
    @(posedge clock);
    #1;
    @(negedge clock);
    checks++;
    if (mValid[0] !== 1'b1 || mData[0] !== 7'h55 || mSrc[0] !== 2'd2) begin
      errors++;
      $display("[TB] FAIL single_arrive: got mvalid=%b data=%h src=%0d, want 1/55/2",
               mValid[0], mData[0], mSrc[0]);
    end
    @(posedge clock);
    #1;
    @(negedge clock);
    checks++;
    if (mValid[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_clear: got mvalid=%b, want 0", mValid[0]);
    end
    @(posedge clock);
    #1;
  endtask

  // Reset in the middle of a burst on producer 1: outputs drop at once and
  // arbitration restarts from id 0.
  task automatic test_reset_mid();
    applyReset();
    sValid[1] = 4'b0010;
    sData[1]  = DIR_DATA;
    mReady[1] = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (mValid[1] !== 1'b0 || sReady[1] !== '0 || fWren[1] !== 1'b0 || fRden[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got mvalid=%b ready=%b wren=%b rden=%b, want all 0",
               mValid[1], sReady[1], fWren[1], fRden[1]);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    sValid[1] = '1;
    @(negedge clock);
    checks++;
    if (sReady[1] !== 4'b0001 || fWdata[1][FW-1 -: IDW] !== 2'd0) begin
      errors++;
      $display("[TB] FAIL midreset_grant: got ready=%b id=%0d, want 0001/0", sReady[1], fWdata[1][FW-1 -: IDW]);
    end
    @(posedge clock);
    #1;
  endtask

  // Random traffic on both instances against a queue model: predicted
  // grants, written words, and the exact consumer order; ends with a drain.
  task automatic test_random();
    int ptrM [2];
    int lockM [2];
    int beatsM [2];
    logic [FW-1:0] sbQ [2][$];
    for (int n = 0; n < 2; n++) begin
      ptrM[n]   = 0;
      lockM[n]  = -1;
      beatsM[n] = 0;
      sbQ[n].delete();
    end
    applyReset();
    for (int c = 0; c < 615; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (c < 600) begin
          sValid[n] = NREQ'($urandom_range(0, 15));
          sData[n]  = (NREQ*DW)'($urandom);
          mReady[n] = ($urandom_range(0, 3) >= ((c < 300) ? 2 : 1));
        end else begin
          sValid[n] = '0;
          mReady[n] = 1'b1;
        end
      end
      @(negedge clock);
      for (int n = 0; n < 2; n++) begin
        int g;
        int expId;
        logic [NREQ-1:0] expReady;
        logic [FW-1:0] expWord;
        logic [FW-1:0] head;
        if (mValid[n]) begin
          checks++;
          if (mReady[n]) begin
            if (sbQ[n].size() == 0) begin
              errors++;
              $display("[TB] FAIL rand_spurious inst%0d c%0d: got word %h, want none", n, c, {mSrc[n], mData[n]});
            end else begin
              head = sbQ[n].pop_front();
              if ({mSrc[n], mData[n]} !== head) begin
                errors++;
                $display("[TB] FAIL rand_order inst%0d c%0d: got %h, want %h", n, c, {mSrc[n], mData[n]}, head);
              end
            end
          end else if (fRden[n] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_stall_rden inst%0d c%0d: got rden=%b, want 0", n, c, fRden[n]);
          end
        end
        expId = -1;
        if (lockM[n] >= 0) begin
          g = lockM[n];
          if (!sValid[n][g]) begin
            ptrM[n]   = (g + 1) % NREQ;
            lockM[n]  = -1;
            beatsM[n] = 0;
          end else if (!fFull[n]) begin
            expId = g;
          end
        end else begin
          g = -1;
          for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && sValid[n][(ptrM[n] + k) % NREQ]) begin
              g = (ptrM[n] + k) % NREQ;
            end
          end
          if (g >= 0 && !fFull[n]) begin
            expId = g;
          end
        end
        expReady = (expId >= 0) ? NREQ'(1 << expId) : '0;
        checks++;
        if (sReady[n] !== expReady || fWren[n] !== (expId >= 0)) begin
          errors++;
          $display("[TB] FAIL rand_grant inst%0d c%0d: got ready=%b wren=%b, want %b/%b",
                   n, c, sReady[n], fWren[n], expReady, expId >= 0);
        end
        if (expId >= 0) begin
          expWord = {IDW'(expId), sData[n][expId*DW +: DW]};
          checks++;
          if (fWdata[n] !== expWord) begin
            errors++;
            $display("[TB] FAIL rand_wdata inst%0d c%0d: got %h, want %h", n, c, fWdata[n], expWord);
          end
          sbQ[n].push_back(expWord);
          if (lockM[n] >= 0) begin
            beatsM[n]++;
            if (beatsM[n] == burstOf(n)) begin
              ptrM[n]   = (expId + 1) % NREQ;
              lockM[n]  = -1;
              beatsM[n] = 0;
            end
          end else if (burstOf(n) > 1) begin
            lockM[n]  = expId;
            beatsM[n] = 1;
          end else begin
            ptrM[n] = (expId + 1) % NREQ;
          end
        end
      end
      @(posedge clock);
      #1;
    end
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (sbQ[n].size() != 0 || mValid[n] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_drain inst%0d: got %0d words pending mvalid=%b, want 0/0",
                 n, sbQ[n].size(), mValid[n]);
      end
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    for (int n = 0; n < 2; n++) begin
      sValid[n] = '0;
      sData[n]  = '0;
      mReady[n] = 1'b0;
    end
    test_reset();
    test_round_robin();
    test_burst();
    test_full();
    test_toggle();
    test_single();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
